crossbar_column_arbiter: RTL and testbench
==========================================

CROSSBAR_COLUMN_ARBITER -- requirements
Module: crossbar_column_arbiter

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 4, meaning the number of master rows competing for this slave column.
REQ-002 The block SHALL have parameter SLAVE_ID, default 0, meaning the 2-bit column index this arbiter owns.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles without s_ack before forced release.
REQ-004 The block SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port m_req  input  N_MASTERS  per-master request (in_req of each row).
REQ-007 The block SHALL have port m_sel  input  2*N_MASTERS  per-master in_addr[31:30]; master i occupies bits [2i+1:2i].
REQ-008 The block SHALL have port s_ack  input  1  slave acknowledge (out_ack of this column).
REQ-009 The block SHALL have port grant  output  N_MASTERS  one-hot connect enable to the column's crosspoints.
REQ-010 The block SHALL have port owner  output  2  index of the granted master; valid only while busy=1.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port timeout_pulse  output  1  one-cycle pulse on forced release.

Function
REQ-013 Master i SHALL be eligible when m_req[i]=1 and m_sel[i] equals SLAVE_ID.
REQ-014 The FSM SHALL have exactly four states: IDLE, BUSY, DONE and RELEASE.
REQ-015 In IDLE with at least one eligible master, the FSM SHALL pick the first eligible index at or after ptr, wrapping modulo N_MASTERS, and enter BUSY.
REQ-016 In IDLE the winner's grant bit SHALL be registered on that same edge, giving 1-cycle latency from eligible request to grant.
REQ-017 In IDLE with no eligible master, the FSM SHALL stay in IDLE with grant=0.
REQ-018 In BUSY, grant SHALL hold, and s_ack=1 SHALL move the FSM to DONE.
REQ-019 In BUSY, m_req[owner]=0 without s_ack (abort) SHALL move the FSM to RELEASE and clear grant.
REQ-020 If s_ack=1 and m_req[owner]=0 occur in the same BUSY cycle, s_ack SHALL win and the FSM SHALL enter DONE.
REQ-021 The BUSY timeout counter SHALL be 8 bits wide, SHALL clear on entry to BUSY and SHALL increment each BUSY cycle without s_ack.
REQ-022 When the counter equals TIMEOUT_CYCLES-1 with s_ack=0, the FSM SHALL clear grant, pulse timeout_pulse for one cycle and enter RELEASE.
REQ-023 In DONE, grant SHALL hold until m_req[owner]=0; then grant SHALL clear and the FSM SHALL enter RELEASE.
REQ-024 In DONE, changes to m_sel SHALL be ignored.
REQ-025 RELEASE SHALL last exactly one cycle with grant=0 (bus turnaround), and SHALL then go to IDLE.
REQ-026 On every exit from BUSY or DONE to RELEASE, ptr SHALL be set to owner+1 modulo N_MASTERS (wrap 3->0).
REQ-027 grant SHALL never have more than one bit set, and SHALL be zero in IDLE and RELEASE.
REQ-028 While the FSM is in BUSY or DONE, eligible requests from other masters SHALL be held off and SHALL NOT be reordered.

Reset
REQ-029 When reset=0 at a clock edge, the block SHALL set state=IDLE, ptr=0, counter=0, grant=0, owner=0, busy=0 and timeout_pulse=0 on that edge.
REQ-030 A reset asserted during BUSY or DONE SHALL drop grant on that same edge, with no RELEASE cycle.
REQ-031 No output SHALL depend on initial blocks.

Structure
REQ-032 A shared package SHALL define the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10, RELEASE=2'b11), the selector width (2) and the default N_MASTERS.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_picker with inputs eligible and ptr, and outputs a one-hot pick and a valid flag.
REQ-034 The top level SHALL instantiate rr_picker and own all registers.

Verification
REQ-035 With ptr=0, m_req=4'b0001 and m_sel[1:0]=SLAVE_ID: grant=4'b0001 one cycle later; s_ack pulse -> DONE; m_req dropped -> RELEASE, then IDLE, ptr=1.
REQ-036 Masters 0 and 2 request simultaneously with ptr=1: grant=4'b0100; after release, ptr=3 and master 0 is granted next.
REQ-037 Master 3 requests with m_sel=SLAVE_ID+1: grant stays 0 and busy stays 0.
REQ-038 Granted master with s_ack held 0: exactly 255 BUSY cycles, then timeout_pulse for one cycle, grant=0, ptr advances.
REQ-039 Abort and s_ack arrive in the same BUSY cycle: FSM enters DONE, grant holds one more cycle, then RELEASE.
REQ-040 reset=0 driven mid-DONE: grant=4'b0000 and busy=0 on that edge; after reset release, ptr=0.

Source files
------------

// File: rtl/crossbar_column_arbiter_pkg.sv
// Shared definitions for the crossbar column arbiter: FSM encoding, selector
// and counter widths, and a small wrap-around index helper.
package crossbar_column_arbiter_pkg;

  localparam int SEL_W             = 2;
  localparam int CNT_W             = 8;
  localparam int DEFAULT_N_MASTERS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_DONE    = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  // Next index after idx, wrapping to zero past the last master.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/crossbar_column_arbiter_if.sv
// Bundle of the per-column request/acknowledge bus and the arbiter's grant outputs.
interface crossbar_column_arbiter_if
  import crossbar_column_arbiter_pkg::*;
#(
  parameter int N_MASTERS = DEFAULT_N_MASTERS
) ();

  logic [N_MASTERS-1:0]       m_req;
  logic [SEL_W*N_MASTERS-1:0] m_sel;
  logic                       s_ack;
  logic [N_MASTERS-1:0]       grant;
  logic [SEL_W-1:0]           owner;
  logic                       busy;
  logic                       timeout_pulse;

  modport master (
    output m_req, m_sel, s_ack,
    input  grant, owner, busy, timeout_pulse
  );

  modport slave (
    input  m_req, m_sel, s_ack,
    output grant, owner, busy, timeout_pulse
  );

endinterface

// File: rtl/crossbar_column_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest eligible index at or above ptr,
// otherwise the lowest eligible index overall (wrap-around).
module rr_picker
  import crossbar_column_arbiter_pkg::*;
#(
  parameter int N_MASTERS = DEFAULT_N_MASTERS
) (
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [SEL_W-1:0]     ptr,
  output logic [N_MASTERS-1:0] pick,
  output logic                 valid
);

  logic [N_MASTERS-1:0] w_mask;
  logic [N_MASTERS-1:0] w_hi;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_mask[i] = (i >= int'(ptr));
    end
  end

  assign w_hi = eligible & w_mask;

  // x & -x isolates the lowest set bit, so pick is one-hot by construction.
  assign pick  = (|w_hi) ? (w_hi & (-w_hi)) : (eligible & (-eligible));
  assign valid = |eligible;

endmodule

// File: rtl/crossbar_column_arbiter.sv
// Per-column arbiter: grants one master at a time to this slave column,
// round-robin fairness, abort handling, BUSY timeout and a turnaround cycle.
module crossbar_column_arbiter
  import crossbar_column_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = DEFAULT_N_MASTERS,
  parameter int SLAVE_ID       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  crossbar_column_arbiter_if.slave    bus
);

  localparam logic [SEL_W-1:0] LP_SLAVE   = SEL_W'(SLAVE_ID);
  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [SEL_W-1:0]     r_owner, w_owner_nxt;
  logic [SEL_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic [N_MASTERS-1:0] w_elig;
  logic [N_MASTERS-1:0] w_pick;
  logic                 w_pick_vld;
  logic [SEL_W-1:0]     w_pick_idx;
  logic                 w_owner_req;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_elig[i] = bus.m_req[i] && (bus.m_sel[SEL_W*i +: SEL_W] == LP_SLAVE);
    end
  end

  rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .pick     (w_pick),
    .valid    (w_pick_vld)
  );

  // Owner's request is tracked on m_req alone: once granted, m_sel no longer matters.
  always_comb begin
    w_pick_idx  = '0;
    w_owner_req = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_pick[i])                w_pick_idx  = SEL_W'(i);
      if (r_owner == SEL_W'(i))     w_owner_req = bus.m_req[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_pick_vld) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_pick;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end

      // s_ack has priority over both timeout and abort.
      ST_BUSY: begin
        if (bus.s_ack) begin
          w_state_nxt = ST_DONE;
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_nxt   = ST_RELEASE;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_ptr_nxt     = wrap_inc(r_owner, N_MASTERS);
        end else if (!w_owner_req) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
          w_ptr_nxt   = wrap_inc(r_owner, N_MASTERS);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (!w_owner_req) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
          w_ptr_nxt   = wrap_inc(r_owner, N_MASTERS);
        end
      end

      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign bus.grant         = r_grant;
  assign bus.owner         = r_owner;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.timeout_pulse = r_timeout;

endmodule

// File: tb/tb_crossbar_column_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of column ownership, turnaround and timeout.
module tb_crossbar_column_arbiter;
  import crossbar_column_arbiter_pkg::*;

  localparam int NM  = 4;
  localparam int SID = 1;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crossbar_column_arbiter_if #(.N_MASTERS(NM)) bus ();

  crossbar_column_arbiter #(
    .N_MASTERS      (NM),
    .SLAVE_ID       (SID),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: who holds the column, whether the slave has acknowledged, how many
  // unacknowledged cycles have elapsed, and whether a turnaround cycle is due.
  int md_holder = -1;
  int md_ptr    = 0;
  int md_waited = 0;
  bit md_acked  = 1'b0;
  bit md_turn   = 1'b0;
  bit md_to     = 1'b0;

  function automatic bit is_eligible(input int i);
    return bus.m_req[i[1:0]] && (bus.m_sel[2*i +: 2] == 2'(SID));
  endfunction

  task automatic md_release();
    md_ptr    = (md_holder + 1) % NM;
    md_holder = -1;
    md_turn   = 1'b1;
  endtask

  task automatic model_step();
    bit found;
    md_to = 1'b0;
    if (!reset) begin
      md_holder = -1;
      md_ptr    = 0;
      md_waited = 0;
      md_acked  = 1'b0;
      md_turn   = 1'b0;
    end else if (md_turn) begin
      md_turn = 1'b0;
    end else if (md_holder < 0) begin
      found = 1'b0;
      for (int k = 0; k < NM; k++) begin
        if (!found && is_eligible((md_ptr + k) % NM)) begin
          found     = 1'b1;
          md_holder = (md_ptr + k) % NM;
          md_acked  = 1'b0;
          md_waited = 0;
        end
      end
    end else if (!md_acked) begin
      if (bus.s_ack) begin
        md_acked = 1'b1;
      end else begin
        md_waited++;
        if (md_waited == TO) begin
          md_to = 1'b1;
          md_release();
        end else if (!bus.m_req[md_holder[1:0]]) begin
          md_release();
        end
      end
    end else if (!bus.m_req[md_holder[1:0]]) begin
      md_release();
    end
  endtask

  task automatic compare();
    chk("grant", 32'(bus.grant), (md_holder >= 0) ? (32'(1) << md_holder) : 32'd0);
    chk("busy", 32'(bus.busy), 32'(md_holder >= 0 || md_turn));
    chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(md_to));
    if (md_holder >= 0) chk("owner", 32'(bus.owner), 32'(md_holder));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    bus.m_req = '0;
    bus.m_sel = {NM{2'(SID)}};
    bus.s_ack = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;

    // Single master, ack, drop request.
    bus.m_req = 4'b0001;
    tick();
    chk("t1_grant", 32'(bus.grant), 32'h1);
    bus.s_ack = 1'b1; tick();
    bus.s_ack = 1'b0; tick(); tick();
    bus.m_req = 4'b0000; tick();
    chk("t1_release_grant", 32'(bus.grant), 32'd0);
    chk("t1_release_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Masters 0 and 2 together with pointer at 1; master 0 follows.
    bus.m_req = 4'b0101;
    tick();
    chk("t2_grant", 32'(bus.grant), 32'h4);
    bus.s_ack = 1'b1; tick();
    bus.s_ack = 1'b0; bus.m_req = 4'b0001;
    tick(); tick(); tick();
    chk("t2_next_grant", 32'(bus.grant), 32'h1);
    bus.s_ack = 1'b1; tick();
    bus.s_ack = 1'b0; bus.m_req = 4'b0000;
    tick(); tick();

    // Request addressed to a different column.
    bus.m_req = 4'b1000;
    bus.m_sel[7:6] = 2'(SID + 1);
    repeat (5) tick();
    chk("t3_grant", 32'(bus.grant), 32'd0);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    bus.m_req = 4'b0000;
    bus.m_sel = {NM{2'(SID)}};
    tick();

    // Timeout with s_ack held low.
    bus.m_req = 4'b0010;
    tick();
    n = 0;
    while (bus.grant != '0 && n < 400) begin
      n++;
      tick();
    end
    chk("t4_busy_cycles", 32'(n), 32'd255);
    chk("t4_timeout_pulse", 32'(bus.timeout_pulse), 32'd1);
    bus.m_req = 4'b0000;
    tick();
    chk("t4_pulse_cleared", 32'(bus.timeout_pulse), 32'd0);
    tick();

    // Abort and ack in the same BUSY cycle.
    bus.m_req = 4'b0100;
    tick();
    bus.m_req = 4'b0000; bus.s_ack = 1'b1;
    tick();
    chk("t5_hold", 32'(bus.grant), 32'h4);
    bus.s_ack = 1'b0;
    tick();
    chk("t5_release", 32'(bus.grant), 32'd0);
    tick();

    // Reset in DONE, then pointer restarts at 0.
    bus.m_req = 4'b1000;
    tick();
    bus.s_ack = 1'b1; tick();
    bus.s_ack = 1'b0; tick();
    reset = 1'b0;
    tick();
    chk("t6_rst_grant", 32'(bus.grant), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    bus.m_req = 4'b1001;
    tick();
    chk("t6_ptr0_grant", 32'(bus.grant), 32'h1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 9) == 0) bus.m_req[i[1:0]] = ~bus.m_req[i[1:0]];
        if ($urandom_range(0, 9) == 0)
          bus.m_sel[2*i +: 2] = ($urandom_range(0, 3) != 0) ? 2'(SID) : 2'($urandom_range(0, 3));
      end
      bus.s_ack = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
